// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer
//
// Drives every input combination of a combinational N_IN-input, 1-output gate
// in ascending binary order. Each vector is held for HOLD clocks and the gate
// output is sampled on the last edge of that window. The sampled truth table
// is compared bit by bit against an expected table latched when the sweep
// starts.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   start          request a sweep; accepted only while not busy
//   expected       expected truth table, bit i = output for input vector i
//   dut_in         registered stimulus to the gate (MSB = first gate input)
//   dut_out        gate output
//   busy           sweep in progress
//   done           results valid; held until the next accepted start
//   pass           captured == expected; valid while done=1
//   captured       sampled truth table, bit i = dut_out for vector i
//   mismatch_count number of differing bits
//   first_fail     lowest mismatching vector index; 0 when pass=1
module truth_table_sequencer #(
  parameter int N_IN = 3,
  parameter int HOLD = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   expected,
  output logic [N_IN-1:0]      dut_in,
  input  logic                 dut_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2**N_IN-1:0]   captured,
  output logic [N_IN:0]        mismatch_count,
  output logic [N_IN-1:0]      first_fail
);

  localparam int              NVEC        = 2**N_IN;
  localparam logic [N_IN-1:0] LAST_VEC    = N_IN'(NVEC - 1);
  localparam logic [7:0]      HOLD_RELOAD = 8'(HOLD - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t              state_reg;
  logic [7:0]          hold_cnt_reg;
  logic [NVEC-1:0]     expected_reg;

  logic                sample_now;
  logic                bit_mismatch;
  logic [N_IN:0]       mismatch_count_next;
  logic [NVEC-1:0]     captured_next;

  // dut_in doubles as the vector index while RUN is active.
  assign sample_now          = (state_reg == RUN) && (hold_cnt_reg == 8'd0);
  assign bit_mismatch        = (dut_out != expected_reg[dut_in]);
  assign mismatch_count_next = mismatch_count + {{N_IN{1'b0}}, bit_mismatch};

  // Only the bit addressed by the active vector is updated on a sample edge.
  genvar gi;
  generate
    for (gi = 0; gi < NVEC; gi++) begin : g_capture
      assign captured_next[gi] = (sample_now && (dut_in == N_IN'(gi))) ? dut_out : captured[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      hold_cnt_reg   <= 8'd0;
      expected_reg   <= '0;
      dut_in         <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      captured       <= '0;
      mismatch_count <= '0;
      first_fail     <= '0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            state_reg      <= RUN;
            hold_cnt_reg   <= HOLD_RELOAD;
            expected_reg   <= expected;
            dut_in         <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            captured       <= '0;
            mismatch_count <= '0;
            first_fail     <= '0;
          end
        end

        RUN: begin
          if (hold_cnt_reg == 8'd0) begin
            captured       <= captured_next;
            mismatch_count <= mismatch_count_next;
            // A zero count before this compare means this is the first miss.
            if (bit_mismatch && (mismatch_count == '0)) begin
              first_fail <= dut_in;
            end
            if (dut_in != LAST_VEC) begin
              dut_in       <= dut_in + 1'b1;
              hold_cnt_reg <= HOLD_RELOAD;
            end else begin
              state_reg <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              dut_in    <= '0;
              // Uses the next count so the final vector's compare is included.
              pass      <= (mismatch_count_next == '0);
            end
          end else begin
            hold_cnt_reg <= hold_cnt_reg - 8'd1;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
